jtframe_romrq_arb: RTL and testbench
====================================

# jtframe_romrq_arb

Four-slot ROM request arbiter that shares the single game-side SDRAM read port (sdram_req/sdram_ack/data_rdy/data_read) of jtframe_mist among the game's ROM consumers: main CPU, sound CPU, character and object graphics fetchers. Each slot keeps a one-entry cache of its last fetched 32-bit word, so repeated reads hit without SDRAM traffic. It sits inside the game module, between the per-subsystem ROM interfaces and the frame's SDRAM port, and gates refresh_en so the frame refreshes only while the port is idle.

## Interface
- OFFSET0, 22'h0, word offset added to slot 0 address
- OFFSET1, 22'h0, word offset added to slot 1 address
- OFFSET2, 22'h0, word offset added to slot 2 address
- OFFSET3, 22'h0, word offset added to slot 3 address

- clk  in  1  system clock (48 MHz)
- rst_n  in  1  asynchronous, active-low reset
- downloading  in  1  ROM download in progress; freezes arbiter, invalidates caches
- slot_cs  in  4  per-slot read request, bit k = slot k
- slot_addr  in  88  packed word addresses, slot k at [22k+21:22k]
- slot_ok  out  4  bit k high: slot_dout for slot k is valid for current slot_addr
- slot_dout  out  128  packed cached data, slot k at [32k+31:32k]
- sdram_req  out  1  read request to frame SDRAM port
- sdram_addr  out  22  word address of current request
- sdram_ack  in  1  one-cycle pulse: request accepted
- data_rdy  in  1  one-cycle pulse: data_read valid
- data_read  in  32  SDRAM read data
- refresh_en  out  1  high when the frame may issue SDRAM refresh

## Operation
- Per-slot cache: valid[k], tag[k] (22 b, slot-relative address), data[k] (32 b).
- Hit[k] = valid[k] & tag[k]==slot_addr[k]; slot_ok[k] = slot_cs[k] & hit[k] (combinational from registered cache and inputs). slot_dout[k] = data[k] always.
- Miss[k] = slot_cs[k] & ~hit[k].
- States: IDLE, WAIT_ACK, WAIT_RDY.
- IDLE: if downloading, stay. Else if any Miss, grant lowest-index missing slot (fixed priority, slot 0 highest); latch gnt index and slot address; sdram_addr <= slot_addr[k] + OFFSETk (mod 2^22); sdram_req <= 1; go WAIT_ACK.
- WAIT_ACK: hold sdram_req and sdram_addr; on sdram_ack, sdram_req <= 0, go WAIT_RDY.
- WAIT_RDY: on data_rdy, tag[gnt] <= latched address, data[gnt] <= data_read, valid[gnt] <= 1, go IDLE.
- An accepted request is never aborted: if slot_cs drops or slot_addr changes during WAIT_ACK/WAIT_RDY the fill still completes with the latched address; a changed address then misses and re-requests.
- downloading high: all valid cleared every cycle; in IDLE no new grants. If asserted in WAIT_ACK/WAIT_RDY, the transaction completes but the fill does not set valid.
- refresh_en = (state==IDLE) & ~(|Miss) | downloading.
- Only 22-bit addresses; offset sum wraps, no carry out.

## Timing
- Reset: state IDLE, sdram_req 0, sdram_addr 0, valid/tag/data 0, slot_ok 0, slot_dout 0, refresh_en 1 when no cs.
- Miss sampled at edge n in IDLE -> sdram_req high from cycle n+1.
- sdram_req falls the cycle after sdram_ack is sampled.
- data_rdy sampled at edge m -> cache updated at m, slot_ok[k] high in cycle m+1 if address unchanged.
- Minimum miss-to-ok latency: 3 cycles plus SDRAM ack/rdy delays; hit: 0 cycles (same cycle as cs).
- Back-to-back: after WAIT_RDY -> IDLE, next grant evaluated in the following cycle (one idle cycle between requests, refresh_en low in it if misses pending).
- sdram_ack and data_rdy arriving in the same cycle are not supported by the frame; if seen in WAIT_ACK, data_rdy is ignored.
- Async reset mid-transaction: immediate return to IDLE, sdram_req 0, all caches invalid.

## Test plan
- Reset release, slot_cs=0 -> sdram_req 0, slot_ok 4'b0000, refresh_en 1.
- Slot 2 cs, addr 22'h00123, OFFSET2=22'h10000, ack 2 cycles later, data_rdy with 32'hDEADBEEF 4 cycles later -> sdram_addr 22'h10123, slot_ok[2] high one cycle after data_rdy, slot_dout[2]=32'hDEADBEEF, refresh_en low throughout.
- Repeat same slot 2 addr -> slot_ok[2] high same cycle, no sdram_req.
- Slots 0 and 3 miss simultaneously -> slot 0 served first, slot 3 granted one cycle after slot 0 fill; both end with ok high.
- Slot 1 addr changes from 22'h00010 to 22'h00011 during WAIT_RDY -> fill tagged 22'h00010, slot_ok[1] stays low, second request to 22'h00011 issued.
- downloading pulsed after fills -> all slot_ok low, next cs to previous addresses re-requests; rst_n low during WAIT_ACK -> sdram_req drops asynchronously.

Source files
------------

// File: rtl/jtframe_romrq_arb_if.sv
// rtl/jtframe_romrq_arb_if.sv - ROM slot and SDRAM read-port bundle for jtframe_romrq_arb
//
// Purpose: groups the four-slot ROM request side and the frame SDRAM read
// port into one bundle.
// Signals:
//   slot_cs[3:0]       per-slot read request
//   slot_addr[87:0]    packed word addresses, slot k at [22k+21:22k]
//   slot_ok[3:0]       slot k data valid for its current address
//   slot_dout[127:0]   packed cached data, slot k at [32k+31:32k]
//   sdram_req          read request to the frame
//   sdram_addr[21:0]   word address of the current request
//   sdram_ack          one-cycle pulse: request accepted
//   data_rdy           one-cycle pulse: data_read valid
//   data_read[31:0]    SDRAM read data
// Modports: master = arbiter side, slave = ROM consumers plus SDRAM frame side.
interface jtframe_romrq_arb_if;
    logic [3:0]   slot_cs;
    logic [87:0]  slot_addr;
    logic [3:0]   slot_ok;
    logic [127:0] slot_dout;
    logic         sdram_req;
    logic [21:0]  sdram_addr;
    logic         sdram_ack;
    logic         data_rdy;
    logic [31:0]  data_read;

    modport master (
        input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        output slot_ok, slot_dout, sdram_req, sdram_addr
    );

    modport slave (
        output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        input  slot_ok, slot_dout, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtframe_romrq_arb.sv
// rtl/jtframe_romrq_arb.sv - four-slot cached ROM request arbiter for the frame SDRAM read port
//
// Purpose: shares one SDRAM read port among four ROM consumers with a
// one-entry 32-bit cache per slot and fixed priority (slot 0 highest).
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_downloading  ROM download in progress: freezes grants, invalidates caches
//   o_refresh_en   frame may refresh (port idle with nothing pending, or downloading)
//   bus            slot request side and SDRAM read port (master modport)
module jtframe_romrq_arb #(
    parameter logic [21:0] OFFSET0 = 22'h0,
    parameter logic [21:0] OFFSET1 = 22'h0,
    parameter logic [21:0] OFFSET2 = 22'h0,
    parameter logic [21:0] OFFSET3 = 22'h0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_downloading,
    output logic                   o_refresh_en,
    jtframe_romrq_arb_if.master    bus
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_valid;
    logic [3:0][21:0] r_tag;
    logic [3:0][31:0] r_data;
    logic [1:0]       r_gnt;
    logic [21:0]      r_lat_addr;
    logic             r_sdram_req;
    logic [21:0]      r_sdram_addr;

    logic [3:0][21:0] w_addr;
    logic [3:0]       w_hit;
    logic [3:0]       w_miss;
    logic             w_any_miss;
    logic [1:0]       w_gnt_idx;
    logic [21:0]      w_offset;
    logic             w_grant;
    logic             w_fill;

    assign w_addr = bus.slot_addr;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_hit[k] = r_valid[k] && (r_tag[k] == w_addr[k]);
        end
    end

    assign w_miss         = bus.slot_cs & ~w_hit;
    assign w_any_miss     = |w_miss;
    assign bus.slot_ok    = bus.slot_cs & w_hit;
    assign bus.slot_dout  = r_data;
    assign bus.sdram_req  = r_sdram_req;
    assign bus.sdram_addr = r_sdram_addr;
    assign o_refresh_en   = ((r_state == IDLE) && !w_any_miss) || i_downloading;

    // Fixed priority: lowest missing slot index wins.
    always_comb begin
        w_gnt_idx = 2'd0;
        if (w_miss[0])      w_gnt_idx = 2'd0;
        else if (w_miss[1]) w_gnt_idx = 2'd1;
        else if (w_miss[2]) w_gnt_idx = 2'd2;
        else if (w_miss[3]) w_gnt_idx = 2'd3;
    end

    always_comb begin
        w_offset = OFFSET0;
        case (w_gnt_idx)
            2'd0: w_offset = OFFSET0;
            2'd1: w_offset = OFFSET1;
            2'd2: w_offset = OFFSET2;
            2'd3: w_offset = OFFSET3;
            default: w_offset = OFFSET0;
        endcase
    end

    // data_rdy is only honoured in WAIT_RDY, so a pulse coinciding with the
    // ack is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_downloading && w_any_miss) begin
                    w_grant     = 1'b1;
                    w_state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.sdram_ack) w_state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (bus.data_rdy) begin
                    w_fill      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid      <= '0;
            r_tag        <= '0;
            r_data       <= '0;
            r_gnt        <= 2'd0;
            r_lat_addr   <= '0;
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= '0;
        end else begin
            if (w_grant) begin
                r_gnt        <= w_gnt_idx;
                r_lat_addr   <= w_addr[w_gnt_idx];
                r_sdram_addr <= w_addr[w_gnt_idx] + w_offset;
                r_sdram_req  <= 1'b1;
            end
            if ((r_state == WAIT_ACK) && bus.sdram_ack) r_sdram_req <= 1'b0;
            // The fill always completes with the latched address; it only
            // becomes visible if no download started meanwhile.
            if (w_fill) begin
                r_tag[r_gnt]  <= r_lat_addr;
                r_data[r_gnt] <= bus.data_read;
                if (!i_downloading) r_valid[r_gnt] <= 1'b1;
            end
            if (i_downloading) r_valid <= '0;
        end
    end

endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// tb/tb_jtframe_romrq_arb.sv - self-checking bench for jtframe_romrq_arb
module tb_jtframe_romrq_arb;

    logic clk;
    logic rst_n;
    logic downloading;
    logic refresh_en;
    int   checks;
    int   errors;

    jtframe_romrq_arb_if bus ();

    jtframe_romrq_arb #(
        .OFFSET0(22'h000000),
        .OFFSET1(22'h000100),
        .OFFSET2(22'h010000),
        .OFFSET3(22'h3FFFF0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_downloading(downloading),
        .o_refresh_en (refresh_en),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       cs;
        logic [3:0][21:0] addr;
        logic [3:0]       ok;
    } vec_t;

    vec_t vecs[6];

    localparam logic [31:0] D_A  = 32'hA5A5_0001;
    localparam logic [31:0] D_B  = 32'h3C3C_0003;
    localparam logic [31:0] D_C  = 32'h1111_0010;
    localparam logic [31:0] D_D  = 32'h2222_0011;
    localparam logic [31:0] D_BE = 32'hDEAD_BEEF;
    localparam logic [31:0] D_F  = 32'hFFFF_0002;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_addr(input int k, input logic [21:0] a);
        bus.slot_addr[22*k +: 22] = a;
    endtask

    // Waits (bounded) for sdram_req, then checks the issued address.
    task automatic wait_req(input string nm, input logic [21:0] exp_addr);
        int n;
        n = 0;
        while (!bus.sdram_req && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk({nm, "_req_seen"}, bus.sdram_req, 1);
        chk({nm, "_sdram_addr"}, bus.sdram_addr, exp_addr);
    endtask

    task automatic do_ack(input string nm, input int ack_dly);
        repeat (ack_dly) begin
            @(negedge clk); #1;
            chk({nm, "_req_hold"}, bus.sdram_req, 1);
            chk({nm, "_refresh_busy"}, refresh_en, 0);
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        #1;
        chk({nm, "_req_drop"}, bus.sdram_req, 0);
    endtask

    task automatic do_rdy(input string nm, input int rdy_dly, input logic [31:0] d, input bit chk_ref);
        repeat (rdy_dly - 1) begin
            @(negedge clk); #1;
            chk({nm, "_req_low"}, bus.sdram_req, 0);
            if (chk_ref) chk({nm, "_refresh_busy2"}, refresh_en, 0);
        end
        bus.data_rdy  = 1'b1;
        bus.data_read = d;
        @(negedge clk);
        bus.data_rdy  = 1'b0;
        bus.data_read = 32'h0;
        #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        downloading    = 1'b0;
        bus.slot_cs    = 4'b0000;
        bus.slot_addr  = '0;
        bus.sdram_ack  = 1'b0;
        bus.data_rdy   = 1'b0;
        bus.data_read  = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req", bus.sdram_req, 0);
        chk("rst_ok", bus.slot_ok, 4'b0000);
        chk("rst_refresh", refresh_en, 1);
        chk("rst_sdram_addr", bus.sdram_addr, 22'h0);
        chk("rst_dout", bus.slot_dout, 128'h0);

        // Slot 2 miss, offset added
        @(negedge clk);
        set_addr(2, 22'h00123);
        bus.slot_cs = 4'b0100;
        #1;
        chk("s2_ok_miss", bus.slot_ok, 4'b0000);
        chk("s2_refresh_miss", refresh_en, 0);
        chk("s2_req_not_yet", bus.sdram_req, 0);
        wait_req("s2", 22'h10123);
        do_ack("s2", 2);
        do_rdy("s2", 4, D_BE, 1'b1);
        chk("s2_ok_fill", bus.slot_ok, 4'b0100);
        chk("s2_dout", bus.slot_dout[64 +: 32], D_BE);
        chk("s2_refresh_idle", refresh_en, 1);

        // Hit: same cycle, no request
        @(negedge clk);
        bus.slot_cs = 4'b0000;
        #1;
        chk("hit_ok_nocs", bus.slot_ok, 4'b0000);
        @(negedge clk);
        bus.slot_cs = 4'b0100;
        #1;
        chk("hit_ok_same_cycle", bus.slot_ok, 4'b0100);
        repeat (3) begin
            @(negedge clk); #1;
            chk("hit_no_req", bus.sdram_req, 0);
        end

        // Slots 0 and 3 miss together; slot 3 offset wraps past 2^22
        @(negedge clk);
        set_addr(0, 22'h00055);
        set_addr(3, 22'h00020);
        bus.slot_cs = 4'b1001;
        #1;
        wait_req("p0", 22'h00055);
        do_ack("p0", 1);
        do_rdy("p0", 2, D_A, 1'b1);
        chk("p0_ok", bus.slot_ok, 4'b0001);
        chk("p_gap_req", bus.sdram_req, 0);
        chk("p_gap_refresh", refresh_en, 0);
        @(negedge clk); #1;
        chk("p3_req_next", bus.sdram_req, 1);
        wait_req("p3", 22'h000010);
        do_ack("p3", 0);
        do_rdy("p3", 1, D_B, 1'b1);
        chk("p_both_ok", bus.slot_ok, 4'b1001);
        chk("p0_dout", bus.slot_dout[0 +: 32], D_A);
        chk("p3_dout", bus.slot_dout[96 +: 32], D_B);

        // Slot 1 address changes during WAIT_RDY
        @(negedge clk);
        set_addr(1, 22'h00010);
        bus.slot_cs = 4'b0010;
        #1;
        wait_req("a1", 22'h00110);
        do_ack("a1", 1);
        set_addr(1, 22'h00011);
        do_rdy("a1", 3, D_C, 1'b1);
        chk("a1_ok_stale", bus.slot_ok, 4'b0000);
        chk("a1_refresh_pending", refresh_en, 0);
        set_addr(1, 22'h00010);
        #1;
        chk("a1_tag_old_addr", bus.slot_ok, 4'b0010);
        chk("a1_dout_old", bus.slot_dout[32 +: 32], D_C);
        @(negedge clk);
        set_addr(1, 22'h00011);
        #1;
        wait_req("a1b", 22'h00111);
        do_ack("a1b", 1);
        do_rdy("a1b", 1, D_D, 1'b1);
        chk("a1b_ok", bus.slot_ok, 4'b0010);
        chk("a1b_dout", bus.slot_dout[32 +: 32], D_D);

        // Table of hit / chip-select combinations against the filled caches
        vecs[0] = '{cs: 4'b1111, addr: {22'h20, 22'h123, 22'h11, 22'h55}, ok: 4'b1111};
        vecs[1] = '{cs: 4'b0001, addr: {22'h20, 22'h123, 22'h11, 22'h55}, ok: 4'b0001};
        vecs[2] = '{cs: 4'b1010, addr: {22'h20, 22'h123, 22'h11, 22'h55}, ok: 4'b1010};
        vecs[3] = '{cs: 4'b0110, addr: {22'h20, 22'h123, 22'h11, 22'h55}, ok: 4'b0110};
        vecs[4] = '{cs: 4'b0101, addr: {22'h21, 22'h123, 22'h10, 22'h55}, ok: 4'b0101};
        vecs[5] = '{cs: 4'b0000, addr: {22'h20, 22'h123, 22'h11, 22'h55}, ok: 4'b0000};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.slot_cs   = vecs[i].cs;
            bus.slot_addr = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d_ok", i), bus.slot_ok, vecs[i].ok);
            chk($sformatf("vec%0d_req", i), bus.sdram_req, 0);
            chk($sformatf("vec%0d_refresh", i), refresh_en, 1);
        end
        chk("vec_dout_all", bus.slot_dout, {D_B, D_BE, D_D, D_A});

        // Download pulse invalidates everything
        @(negedge clk);
        bus.slot_cs   = 4'b1111;
        bus.slot_addr = {22'h20, 22'h123, 22'h11, 22'h55};
        downloading   = 1'b1;
        #1;
        chk("dl_refresh", refresh_en, 1);
        repeat (2) begin
            @(negedge clk); #1;
            chk("dl_ok_low", bus.slot_ok, 4'b0000);
            chk("dl_no_req", bus.sdram_req, 0);
        end
        bus.slot_cs = 4'b0100;
        downloading = 1'b0;
        #1;
        chk("dl_after_ok", bus.slot_ok, 4'b0000);
        chk("dl_after_refresh", refresh_en, 0);
        wait_req("dl_rereq", 22'h10123);
        do_ack("dl_rereq", 1);
        downloading = 1'b1;
        do_rdy("dl_fill", 2, D_F, 1'b0);
        chk("dl_fill_invalid", bus.slot_ok, 4'b0000);
        @(negedge clk);
        downloading = 1'b0;
        #1;
        chk("dl_fill_still_invalid", bus.slot_ok, 4'b0000);
        wait_req("dl_rereq2", 22'h10123);

        // Asynchronous reset while waiting for ack
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", bus.sdram_req, 0);
        chk("arst_addr", bus.sdram_addr, 22'h0);
        chk("arst_ok", bus.slot_ok, 4'b0000);
        chk("arst_dout", bus.slot_dout, 128'h0);
        @(negedge clk);
        bus.slot_cs = 4'b0000;
        rst_n = 1'b1;
        #1;
        chk("arst_release_refresh", refresh_en, 1);
        @(negedge clk); #1;
        chk("arst_release_req", bus.sdram_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
